// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo note decoder.
// Nominal periods are in 50 MHz clk cycles for one full piezo cycle.
package piezo_pkg;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        G6      = 3'd1,
        C7      = 3'd2,
        E7      = 3'd3,
        G7      = 3'd4,
        UNKNOWN = 3'd7
    } note_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam logic [15:0] G6_PERIOD = 16'd31888;
    localparam logic [15:0] C7_PERIOD = 16'd23889;
    localparam logic [15:0] E7_PERIOD = 16'd18961;
    localparam logic [15:0] G7_PERIOD = 16'd15944;

    localparam int          DUR_W   = 12;
    localparam logic [11:0] DUR_MAX = 12'hFFF;

endpackage

// File: rtl/piezo_note_decoder_if.sv
// Completed-note report bus from the decoder (master) to its consumer (slave).
// Plain registered outputs: no handshake, the consumer must sample note_vld every cycle.
interface piezo_note_decoder_if;
    import piezo_pkg::*;

    logic             note_vld;
    logic [2:0]       note_id;
    logic [DUR_W-1:0] note_dur;
    logic             active;
    logic             diff_err;

    modport master (output note_vld, note_id, note_dur, active, diff_err);
    modport slave  (input  note_vld, note_id, note_dur, active, diff_err);

endinterface

// File: rtl/piezo_period_meas.sv
// Synchronizes the piezo drive, measures rising-edge to rising-edge periods and classifies them.
// Latency: edge strobe/class 3 clk after piezo rises; period latched on the strobe. No backpressure.
// With PIEZO_DIFF_CHK_EN defined, also synchronizes piezo_n and flags piezo_n == piezo.
module piezo_period_meas
    import piezo_pkg::*;
#(
    parameter int TOL          = 400,
    parameter int SILENCE_CYC  = 40000,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        piezo,
    input  logic        piezo_n,
    output logic        edge_stb,
    output logic [15:0] period,
    output note_t       note_class,
    output logic        silence_stb,
    output logic        diff_hit
);

    // PERIOD_SHIFT scales all nominals down together, for shortened simulation runs.
    localparam logic [15:0] NOM_G6 = G6_PERIOD >> PERIOD_SHIFT;
    localparam logic [15:0] NOM_C7 = C7_PERIOD >> PERIOD_SHIFT;
    localparam logic [15:0] NOM_E7 = E7_PERIOD >> PERIOD_SHIFT;
    localparam logic [15:0] NOM_G7 = G7_PERIOD >> PERIOD_SHIFT;
    localparam logic [15:0] SIL16  = 16'(SILENCE_CYC);

    logic [2:0]  p_sync;
    logic [15:0] cnt;

    function automatic logic near(input logic [15:0] p, input logic [15:0] nom);
        int d;
        d = int'(p) - int'(nom);
        return (d <= TOL) && (d >= -TOL);
    endfunction

    function automatic note_t classify(input logic [15:0] p);
        note_t r;
        r = UNKNOWN;
        if (near(p, NOM_G6))      r = G6;
        else if (near(p, NOM_C7)) r = C7;
        else if (near(p, NOM_E7)) r = E7;
        else if (near(p, NOM_G7)) r = G7;
        return r;
    endfunction

    // p_sync[1] is the synchronized level, p_sync[2] its previous value.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_sync <= '0;
            cnt    <= '0;
            period <= '0;
        end else begin
            p_sync <= {p_sync[1:0], piezo};
            if (edge_stb) begin
                cnt    <= 16'd1;
                period <= cnt;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign edge_stb    = p_sync[1] & ~p_sync[2];
    assign silence_stb = ~edge_stb & (cnt == SIL16);
    assign note_class  = classify(cnt);

`ifdef PIEZO_DIFF_CHK_EN
    logic [1:0] n_sync;
    logic [1:0] arm;
    logic       eq_q;
    logic       eq_now;

    // arm holds off the compare until both synchronizers carry sampled data, not reset zeros.
    assign eq_now = arm[1] & (n_sync[1] == p_sync[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            n_sync <= '0;
            arm    <= '0;
            eq_q   <= 1'b0;
        end else begin
            n_sync <= {n_sync[0], piezo_n};
            arm    <= {arm[0], 1'b1};
            eq_q   <= eq_now;
        end
    end

    assign diff_hit = eq_now & eq_q;
`else
    logic unused_piezo_n;
    assign unused_piezo_n = piezo_n;
    assign diff_hit       = 1'b0;
`endif

endmodule

// File: rtl/piezo_note_decoder.sv
// Decodes piezo tones into {note_id, note_dur} reports; optional diff check via PIEZO_DIFF_CHK_EN.
// Latency: report registered 1 clk after the terminating edge or silence strobe.
// Backpressure: none; note_vld is a single-cycle pulse and id/dur hold until the next report.
module piezo_note_decoder
    import piezo_pkg::*;
#(
    parameter int TOL          = 400,
    parameter int SILENCE_CYC  = 40000,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 piezo,
    input  logic                 piezo_n,
    piezo_note_decoder_if.master note
);

    logic             edge_stb;
    logic             silence_stb;
    logic             diff_hit;
    note_t            note_class;
    logic [15:0]      unused_period;
    state_t           state;
    note_t            cur_note;
    logic [DUR_W-1:0] dur;

    piezo_period_meas #(
        .TOL          (TOL),
        .SILENCE_CYC  (SILENCE_CYC),
        .PERIOD_SHIFT (PERIOD_SHIFT)
    ) u_meas (
        .clk         (clk),
        .rst         (rst),
        .piezo       (piezo),
        .piezo_n     (piezo_n),
        .edge_stb    (edge_stb),
        .period      (unused_period),
        .note_class  (note_class),
        .silence_stb (silence_stb),
        .diff_hit    (diff_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_note      <= NONE;
            dur           <= '0;
            note.note_vld <= 1'b0;
            note.note_id  <= 3'd0;
            note.note_dur <= '0;
            note.active   <= 1'b0;
            note.diff_err <= 1'b0;
        end else begin
            note.note_vld <= 1'b0;
            if (diff_hit) begin
                note.diff_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (edge_stb) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_stb) begin
                        cur_note    <= note_class;
                        dur         <= 12'd1;
                        state       <= TRACK;
                        note.active <= 1'b1;
                    end else if (silence_stb) begin
                        state <= IDLE;
                    end
                end
                TRACK: begin
                    if (edge_stb) begin
                        if (note_class == cur_note) begin
                            if (dur != DUR_MAX) begin
                                dur <= dur + 12'd1;
                            end
                        end else begin
                            note.note_vld <= 1'b1;
                            note.note_id  <= cur_note;
                            note.note_dur <= dur;
                            cur_note      <= note_class;
                            dur           <= 12'd1;
                        end
                    end else if (silence_stb) begin
                        note.note_vld <= 1'b1;
                        note.note_id  <= cur_note;
                        note.note_dur <= dur;
                        state         <= IDLE;
                        note.active   <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    note.active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piezo_note_decoder.sv
// Directed bench: tones are lists of rising-edge intervals; a run-length model predicts the reports.
// Periods scaled by 2^10 (G6 31, C7 23, E7 18, G7 15 cycles), TOL 1, silence 40 cycles.
module tb_piezo_note_decoder;

    localparam int TOL   = 1;
    localparam int SIL   = 40;
    localparam int SHIFT = 10;
    localparam int NOM [4] = '{31, 23, 18, 15};
`ifdef PIEZO_DIFF_CHK_EN
    localparam int EXP_DIFF_SET = 1;
`else
    localparam int EXP_DIFF_SET = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic piezo = 1'b0;
    logic piezo_n = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int exp_id[$];
    int exp_dur[$];
    int got_id[$];
    int got_dur[$];
    int burst[$];
    int hold_id = 0;
    int hold_dur = 0;
    int exp_diff = 0;
    bit diff_win = 1'b0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    piezo_note_decoder_if nif ();

    piezo_note_decoder #(
        .TOL          (TOL),
        .SILENCE_CYC  (SIL),
        .PERIOD_SHIFT (SHIFT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .piezo   (piezo),
        .piezo_n (piezo_n),
        .note    (nif)
    );

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int cls(input int g);
        for (int k = 0; k < 4; k++) begin
            if ((g - NOM[k] <= TOL) && (NOM[k] - g <= TOL)) return k + 1;
        end
        return 7;
    endfunction

    task automatic push_exp(input int id, input int len);
        exp_id.push_back(id);
        exp_dur.push_back((len > 4095) ? 4095 : len);
    endtask

    // Each maximal run of same-class intervals is one report; a gap beyond SIL ends the tone.
    task automatic model_burst();
        int cur;
        int len;
        int c;
        int g;
        cur = 0;
        len = 0;
        for (int i = 1; i < burst.size(); i++) begin
            g = burst[i];
            if (g > SIL) begin
                if (len > 0) push_exp(cur, len);
                len = 0;
            end else begin
                c = cls(g);
                if (len > 0 && c == cur) begin
                    len++;
                end else begin
                    if (len > 0) push_exp(cur, len);
                    cur = c;
                    len = 1;
                end
            end
        end
        if (len > 0) push_exp(cur, len);
    endtask

    task automatic new_burst();
        burst.delete();
        burst.push_back(0);
    endtask

    task automatic add(input int g, input int n);
        repeat (n) burst.push_back(g);
    endtask

    task automatic play_burst(input bit chk_act);
        int nxt;
        int hi;
        model_burst();
        for (int i = 0; i < burst.size(); i++) begin
            nxt = (i + 1 < burst.size()) ? burst[i + 1] : SIL + 20;
            hi  = nxt / 2;
            piezo = 1'b1;
            piezo_n = 1'b0;
            cyc(hi);
            if (chk_act && i == 0) check("active after first edge", int'(nif.active), 0);
            if (chk_act && i == 1) check("active after second edge", int'(nif.active), 1);
            piezo = 1'b0;
            piezo_n = 1'b1;
            cyc(nxt - hi);
        end
        check("reports drained", exp_id.size(), 0);
        check("active after silence", int'(nif.active), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        hold_id = 0;
        hold_dur = 0;
        exp_diff = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_prev(input string name, input int back, input int id, input int dur);
        if (got_id.size() < back) begin
            check({name, " count"}, got_id.size(), back);
        end else begin
            check({name, " id"}, got_id[got_id.size() - back], id);
            check({name, " dur"}, got_dur[got_id.size() - back], dur);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                if (nif.note_vld) begin
                    got_id.push_back(int'(nif.note_id));
                    got_dur.push_back(int'(nif.note_dur));
                    if (exp_id.size() == 0) begin
                        check("unexpected note_vld", 1, 0);
                    end else begin
                        hold_id = exp_id.pop_front();
                        hold_dur = exp_dur.pop_front();
                    end
                end
                check("note_id", int'(nif.note_id), hold_id);
                check("note_dur", int'(nif.note_dur), hold_dur);
                if (!diff_win) check("diff_err", int'(nif.diff_err), exp_diff);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cyc(3);
        check("reset note_vld", int'(nif.note_vld), 0);
        check("reset note_id", int'(nif.note_id), 0);
        check("reset note_dur", int'(nif.note_dur), 0);
        check("reset active", int'(nif.active), 0);
        check("reset diff_err", int'(nif.diff_err), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(50);

        // G6 x10 edges -> {1,9}
        new_burst(); add(31, 9); play_burst(1'b1);
        check_prev("G6 tone", 1, 1, 9);

        // C7 then E7 -> {2,4} at the change, {3,5} at silence
        new_burst(); add(23, 4); add(18, 5); play_burst(1'b1);
        check_prev("C7 run", 2, 2, 4);
        check_prev("E7 run", 1, 3, 5);

        // period matching nothing -> {7,3}
        new_burst(); add(20, 3); play_burst(1'b1);
        check_prev("unknown tone", 1, 7, 3);

        // tolerance edges: 32/30 G6, 33/29 unknown, 16/14 G7, 17 E7
        new_burst();
        add(32, 1); add(30, 1); add(33, 1); add(29, 1);
        add(16, 1); add(14, 1); add(17, 1);
        play_burst(1'b1);
        check_prev("tol G6", 4, 1, 2);
        check_prev("tol unknown", 3, 7, 2);
        check_prev("tol G7", 2, 4, 2);
        check_prev("tol E7", 1, 3, 1);

        // edge landing exactly on the silence count wins
        new_burst(); add(31, 2); add(40, 1); add(31, 1); play_burst(1'b1);
        check_prev("coincide unknown", 2, 7, 1);
        check_prev("coincide G6", 1, 1, 1);

        // gap past silence: measure-only tone is dropped, tracked tone is reported
        new_burst(); add(41, 1); add(31, 2); add(41, 1); add(31, 1); play_burst(1'b0);
        check_prev("split first", 2, 1, 2);
        check_prev("split second", 1, 1, 1);

        // reset mid-G7 tone discards it; tracking resumes on the second edge after
        repeat (4) begin
            piezo = 1'b1; piezo_n = 1'b0; cyc(7);
            piezo = 1'b0; piezo_n = 1'b1; cyc(8);
        end
        piezo = 1'b1; piezo_n = 1'b0; cyc(7);
        piezo = 1'b0; piezo_n = 1'b1; cyc(3);
        do_reset();
        check("rst mid-note active", int'(nif.active), 0);
        check("rst mid-note note_vld", int'(nif.note_vld), 0);
        cyc(5);
        new_burst(); add(15, 3); play_burst(1'b1);
        check_prev("after reset G7", 1, 4, 3);

        // duration saturates
        new_burst(); add(15, 4199); play_burst(1'b1);
        check_prev("saturated G7", 1, 4, 4095);

        // single-cycle equality never trips the diff check
        piezo_n = 1'b0; cyc(1); piezo_n = 1'b1; cyc(10);
        // three-cycle equality trips it (when enabled) and it sticks
        diff_win = 1'b1;
        piezo_n = 1'b0; cyc(3); piezo_n = 1'b1; cyc(6);
        exp_diff = EXP_DIFF_SET;
        diff_win = 1'b0;
        cyc(20);
        check("diff_err sticky", int'(nif.diff_err), EXP_DIFF_SET);
        do_reset();
        cyc(5);
        check("diff_err after rst", int'(nif.diff_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/piezo_note_decoder.md
PIEZO_NOTE_DECODER -- requirements
Module: piezo_note_decoder

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter TOL, default 400, SHALL set the allowed ± deviation in clk cycles when matching a measured period to a nominal note period.
REQ-003 Parameter SILENCE_CYC, default 40000, SHALL set the cycle count without a rising edge that ends a note.
REQ-004 Port clk, input, 1, SHALL be the 50 MHz system clock.
REQ-005 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-006 Port piezo, input, 1, SHALL be the asynchronous piezo drive square wave under observation.
REQ-007 Port piezo_n, input, 1, SHALL be the complementary piezo drive.
REQ-008 Port note_vld, output, 1, SHALL be a one-cycle pulse marking a completed note.
REQ-009 Port note_id, output, 3, SHALL be the completed note code: 0 NONE, 1 G6, 2 C7, 3 E7, 4 G7, 7 UNKNOWN.
REQ-010 Port note_dur, output, 12, SHALL be the completed note length in piezo periods.
REQ-011 Port active, output, 1, SHALL be high while a note is being tracked.
REQ-012 Port diff_err, output, 1, SHALL be a sticky flag set when piezo_n fails to equal ~piezo.

Function
REQ-013 piezo and piezo_n SHALL each pass through a two-flop synchronizer; a rising edge is sync stage 2 going 0→1.
REQ-014 A 16-bit period counter SHALL increment every clk, saturate at 16'hFFFF, and load 1 on each rising edge.
REQ-015 The period latched on an edge SHALL be classified against 31888 (G6), 23889 (C7), 18961 (E7) and 15944 (G7), with a match when |period−nominal| ≤ TOL; otherwise UNKNOWN.
REQ-016 The FSM SHALL have states IDLE, MEASURE and TRACK.
REQ-017 In IDLE, a rising edge SHALL enter MEASURE.
REQ-018 In MEASURE, a rising edge SHALL classify the period, load cur_note and set dur=1, then enter TRACK.
REQ-019 In TRACK, a rising edge whose class equals cur_note SHALL increment dur, saturating at 4095.
REQ-020 In TRACK, a rising edge whose class differs from cur_note SHALL emit {cur_note, dur}, load the new class, set dur=1 and remain in TRACK.
REQ-021 When the counter reaches SILENCE_CYC with no edge, MEASURE SHALL return to IDLE without emitting.
REQ-022 When the counter reaches SILENCE_CYC with no edge, TRACK SHALL emit {cur_note, dur} and return to IDLE.
REQ-023 If an edge and the SILENCE_CYC threshold coincide in the same cycle, the edge SHALL take priority.
REQ-024 note_vld, note_id and note_dur SHALL be registered and update one cycle after the terminating event; note_id and note_dur SHALL hold their values until the next emission.
REQ-025 active SHALL equal (state == TRACK).

Reset
REQ-026 rst SHALL force IDLE, period counter 0, synchronizers 0, note_vld 0, note_id 0, note_dur 0, active 0 and diff_err 0.
REQ-027 rst asserted mid-note SHALL discard the note with no emission.

Configuration
REQ-028 With PIEZO_DIFF_CHK_EN defined, diff_err SHALL set whenever synchronized piezo_n == synchronized piezo for 2 consecutive cycles, and clear only on rst.
REQ-029 Without PIEZO_DIFF_CHK_EN, piezo_n SHALL be unused, its synchronizer absent, and diff_err tied 0.

Structure
REQ-030 Package piezo_pkg SHALL hold the note_t enum (NONE, G6, C7, E7, G7, UNKNOWN), the four nominal period constants and the FSM state enum.
REQ-031 Synchronizer, edge detect, period counter and classifier SHALL live in sub-module piezo_period_meas, which outputs an edge strobe, the latched period, the class and a silence strobe.
REQ-032 The top level SHALL contain the FSM, duration counter and output registers.

Verification
REQ-033 Drive a G6 square wave (period 31888) for 10 periods, then idle 40000 cycles → one note_vld with note_id=1, note_dur=9.
REQ-034 Drive C7 ×5 periods, then E7 ×5 periods, then silence → note_vld {2,4} at the C7→E7 change, then {3,5} at silence.
REQ-035 Drive period 20000 (outside TOL of every note) for 4 periods, then silence → {7,3}.
REQ-036 Assert rst for 1 cycle mid-G7 tone → no note_vld, active=0; tracking resumes on the second following edge.
REQ-037 With PIEZO_DIFF_CHK_EN, hold piezo_n=piezo for 3 cycles → diff_err=1 and sticky until rst; without the macro, diff_err stays 0.
REQ-038 Drive a G7 tone for 5000 periods → note_dur saturates at 4095.
